// File: rtl/axi_ram_pkg.sv
// Shared types and constants for the AXI3 RAM slave: FSM states, response codes
// and the largest burst-length field the slave honours.
package axi_ram_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD_FETCH,
        RD_DATA,
        WR_DATA,
        WR_RESP
    } state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [3:0] MAX_LEN     = 4'hF;

    function automatic logic [1:0] resp_of(input logic err);
        return err ? RESP_SLVERR : RESP_OKAY;
    endfunction

endpackage

// File: rtl/axi_ram_slave_sp_ram.sv
// Single-port synchronous RAM, 32-bit words, per-byte write enables and a
// registered read port that only updates when a read is requested.
module sp_ram #(
    parameter int MEM_AW = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [MEM_AW-1:0] i_addr,
    input  logic [3:0]        i_we,
    input  logic [31:0]       i_wdata,
    input  logic              i_re,
    output logic [31:0]       o_rdata
);

    logic [31:0] r_mem [2**MEM_AW];
    logic [31:0] r_rdata;

    // NOTE: the storage array is deliberately left out of reset so it maps onto
    // block RAM; only the read-data register is cleared.
    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (i_we[b]) begin
                r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
            end
        end
    end

    // Holding the read register when idle keeps rdata stable under backpressure.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdata <= 32'd0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/axi_ram_slave.sv
// AXI3 slave that serves one INCR burst at a time (1-16 full-width beats) from
// an on-chip word-addressed RAM; oversize lengths are served but flagged SLVERR.
module axi_ram_slave
    import axi_ram_pkg::*;
#(
    parameter int MEM_AW = 12
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  arid,
    input  logic [31:0] araddr,
    input  logic [7:0]  arlen,
    input  logic        arvalid,
    output logic        arready,
    output logic [3:0]  rid,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        rlast,
    output logic        rvalid,
    input  logic        rready,
    input  logic [3:0]  awid,
    input  logic [31:0] awaddr,
    input  logic [7:0]  awlen,
    input  logic        awvalid,
    output logic        awready,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic        wlast,
    input  logic        wvalid,
    output logic        wready,
    output logic [3:0]  bid,
    output logic [1:0]  bresp,
    output logic        bvalid,
    input  logic        bready
);

    state_t              r_state;
    logic [MEM_AW-1:0]   r_addr;
    logic [3:0]          r_cnt;
    logic                r_err;
    logic [3:0]          w_we;
    logic                w_re;
    logic                w_unused;

    // NOTE: readies are combinational but masked by rst so the master never sees
    // a handshake offered while the slave is being reset.
    assign arready = (r_state == IDLE) && !rst;
    assign awready = (r_state == IDLE) && !rst && !arvalid;
    assign wready  = (r_state == WR_DATA) && !rst;

    assign w_re = (r_state == RD_FETCH);
    assign w_we = (wready && wvalid) ? wstrb : 4'b0000;

    assign w_unused = ^{araddr[31:MEM_AW+2], araddr[1:0],
                        awaddr[31:MEM_AW+2], awaddr[1:0]};

    sp_ram #(.MEM_AW(MEM_AW)) u_ram (
        .clk     (clk),
        .rst     (rst),
        .i_addr  (r_addr),
        .i_we    (w_we),
        .i_wdata (wdata),
        .i_re    (w_re),
        .o_rdata (rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_addr  <= '0;
            r_cnt   <= 4'd0;
            r_err   <= 1'b0;
            rid     <= 4'd0;
            rresp   <= RESP_OKAY;
            rlast   <= 1'b0;
            rvalid  <= 1'b0;
            bid     <= 4'd0;
            bresp   <= RESP_OKAY;
            bvalid  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (arvalid) begin
                        rid     <= arid;
                        r_addr  <= araddr[MEM_AW+1:2];
                        r_cnt   <= arlen[3:0];
                        rresp   <= resp_of(arlen[7:4] != 4'd0);
                        r_state <= RD_FETCH;
                    end else if (awvalid) begin
                        bid     <= awid;
                        r_addr  <= awaddr[MEM_AW+1:2];
                        r_cnt   <= awlen[3:0];
                        r_err   <= (awlen[7:4] != 4'd0);
                        r_state <= WR_DATA;
                    end
                end
                RD_FETCH: begin
                    rlast   <= (r_cnt == 4'd0);
                    rvalid  <= 1'b1;
                    r_state <= RD_DATA;
                end
                RD_DATA: begin
                    if (rready) begin
                        rvalid <= 1'b0;
                        rlast  <= 1'b0;
                        if (rlast) begin
                            r_state <= IDLE;
                        end else begin
                            r_addr  <= r_addr + 1'b1;
                            r_cnt   <= r_cnt - 1'b1;
                            r_state <= RD_FETCH;
                        end
                    end
                end
                WR_DATA: begin
                    if (wvalid) begin
                        r_addr <= r_addr + 1'b1;
                        // r_cnt counts expected beats still owed after this one.
                        if (wlast) begin
                            bresp   <= resp_of(r_err || (r_cnt != 4'd0));
                            bvalid  <= 1'b1;
                            r_state <= WR_RESP;
                        end else if (r_cnt == 4'd0) begin
                            r_err <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt - 1'b1;
                        end
                    end
                end
                WR_RESP: begin
                    if (bready) begin
                        bvalid  <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_ram_slave.sv
// Randomised scoreboard bench for axi_ram_slave: tasks push expected beats from
// a word-array memory model, a negedge monitor pops and compares them.
module tb_axi_ram_slave;

    localparam int AW    = 12;
    localparam int DEPTH = 1 << AW;

    logic        clk, rst;
    logic [3:0]  arid, rid, awid, bid, wstrb;
    logic [31:0] araddr, awaddr, rdata, wdata;
    logic [7:0]  arlen, awlen;
    logic        arvalid, arready, rlast, rvalid, rready;
    logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic [1:0]  rresp, bresp;

    axi_ram_slave #(.MEM_AW(AW)) dut (
        .clk(clk), .rst(rst),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  id;
        logic [31:0] data;
        logic        chk;
        logic [1:0]  resp;
        logic        last;
    } rexp_t;

    typedef struct {
        logic [3:0] id;
        logic [1:0] resp;
    } bexp_t;

    rexp_t       rq[$];
    bexp_t       bq[$];
    logic [31:0] model [DEPTH];
    bit          known [DEPTH];
    logic [31:0] wbuf [16];
    logic [3:0]  sbuf [16];
    bit          rr_stall = 1'b0;
    int          passed = 0;
    int          total  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic timeout_fail(input string name);
        total++;
        $display("FAIL %s: timed out waiting for the DUT", name);
    endtask

    // Master-side ready generators.
    initial begin
        rready = 1'b0;
        bready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            rready = rr_stall ? 1'b0 : ($urandom_range(0, 3) != 0);
            bready = ($urandom_range(0, 2) != 0);
        end
    end

    // Monitor: compares presented beats against the scoreboard and checks that
    // stalled outputs hold.
    initial begin : monitor
        rexp_t       re;
        bexp_t       be;
        logic        prev_r, prev_b;
        logic [31:0] snap_rdata, snap_rctl, snap_bctl;
        prev_r = 1'b0;
        prev_b = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_r = 1'b0;
                prev_b = 1'b0;
            end else begin
                if (prev_r) begin
                    check("r_hold_data", rdata, snap_rdata);
                    check("r_hold_ctl", {24'd0, rvalid, rlast, rresp, rid}, snap_rctl);
                end
                if (prev_b) check("b_hold", {25'd0, bvalid, bresp, bid}, snap_bctl);
                if (rvalid && rready) begin
                    if (rq.size() == 0) begin
                        total++;
                        $display("FAIL r_unexpected: beat rdata=%h with nothing expected", rdata);
                    end else begin
                        re = rq.pop_front();
                        if (re.chk) check("rdata", rdata, re.data);
                        check("rid", {28'd0, rid}, {28'd0, re.id});
                        check("rresp", {30'd0, rresp}, {30'd0, re.resp});
                        check("rlast", {31'd0, rlast}, {31'd0, re.last});
                    end
                end
                if (bvalid && bready) begin
                    if (bq.size() == 0) begin
                        total++;
                        $display("FAIL b_unexpected: response bid=%h with nothing expected", bid);
                    end else begin
                        be = bq.pop_front();
                        check("bid", {28'd0, bid}, {28'd0, be.id});
                        check("bresp", {30'd0, bresp}, {30'd0, be.resp});
                    end
                end
                prev_r     = rvalid && !rready;
                prev_b     = bvalid && !bready;
                snap_rdata = rdata;
                snap_rctl  = {24'd0, rvalid, rlast, rresp, rid};
                snap_bctl  = {25'd0, bvalid, bresp, bid};
            end
        end
    end

    task automatic drain();
        int n = 0;
        while ((rq.size() != 0 || bq.size() != 0) && n < 3000) begin
            @(posedge clk);
            n++;
        end
        if (n >= 3000) timeout_fail("drain");
        @(posedge clk);
        #1;
    endtask

    task automatic push_read(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len);
        logic [AW-1:0] w, a;
        rexp_t         e;
        int            beats;
        w     = addr[AW+1:2];
        beats = int'(len[3:0]) + 1;
        for (int i = 0; i < beats; i++) begin
            a      = w + AW'(i);
            e.id   = id;
            e.data = model[a];
            e.chk  = known[a];
            e.resp = (len[7:4] != 4'd0) ? 2'b10 : 2'b00;
            e.last = (i == beats - 1);
            rq.push_back(e);
        end
    endtask

    task automatic push_write(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                              input int nbeats);
        logic [AW-1:0] w, a;
        bexp_t         e;
        w = addr[AW+1:2];
        for (int i = 0; i < nbeats; i++) begin
            a = w + AW'(i);
            for (int b = 0; b < 4; b++)
                if (sbuf[i][b]) model[a][8*b +: 8] = wbuf[i][8*b +: 8];
            known[a] = known[a] || (sbuf[i] == 4'hF);
        end
        e.id   = id;
        e.resp = (len[7:4] != 4'd0 || nbeats != int'(len[3:0]) + 1) ? 2'b10 : 2'b00;
        bq.push_back(e);
    endtask

    task automatic wait_aw();
        int n = 0;
        @(negedge clk);
        while (!awready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!awready) timeout_fail("aw_accept");
        @(posedge clk);
        #1;
        awvalid = 1'b0;
    endtask

    task automatic send_wbeats(input int nbeats);
        int n;
        for (int i = 0; i < nbeats; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                wvalid = 1'b0;
                @(posedge clk);
                #1;
            end
            wvalid = 1'b1;
            wdata  = wbuf[i];
            wstrb  = sbuf[i];
            wlast  = (i == nbeats - 1);
            n = 0;
            @(negedge clk);
            while (!wready && n < 300) begin
                @(negedge clk);
                n++;
            end
            if (!wready) timeout_fail("w_accept");
            @(posedge clk);
            #1;
        end
        wvalid = 1'b0;
        wlast  = 1'b0;
        @(negedge clk);
        check("b_latency", {31'd0, bvalid}, 32'd1);
    endtask

    task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                            input int nbeats);
        push_write(id, addr, len, nbeats);
        awid    = id;
        awaddr  = addr;
        awlen   = len;
        awvalid = 1'b1;
        wait_aw();
        send_wbeats(nbeats);
        drain();
    endtask

    task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input bit wait_done);
        int n = 0;
        push_read(id, addr, len);
        arid    = id;
        araddr  = addr;
        arlen   = len;
        arvalid = 1'b1;
        @(negedge clk);
        while (!arready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!arready) timeout_fail("ar_accept");
        @(posedge clk);
        #1;
        arvalid = 1'b0;
        @(negedge clk);
        check("rd_latency_n1", {31'd0, rvalid}, 32'd0);
        @(negedge clk);
        check("rd_latency_n2", {31'd0, rvalid}, 32'd1);
        if (wait_done) drain();
    endtask

    function automatic logic [31:0] rand_addr();
        int base;
        base = ($urandom_range(0, 3) == 0) ? (DEPTH - 8 + $urandom_range(0, 7)) : $urandom_range(0, 47);
        return 32'(base * 4 + $urandom_range(0, 3));
    endfunction

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int n;
        logic [7:0] len;
        int nb;
        rst = 1'b1;
        {arid, araddr, arlen, arvalid} = '0;
        {awid, awaddr, awlen, awvalid} = '0;
        {wdata, wstrb, wlast, wvalid}  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_rvalid", {31'd0, rvalid}, 32'd0);
        check("rst_bvalid", {31'd0, bvalid}, 32'd0);
        check("rst_readies", {29'd0, arready, awready, wready}, 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_rctl", {23'd0, rid, rresp, rlast, bid[2:0]}, 32'd0);
        check("rst_bctl", {26'd0, bid, bresp}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("idle_readies", {30'd0, arready, awready}, 32'd3);
        @(posedge clk);
        #1;

        // Fill the exercised windows with known data.
        for (int blk = 0; blk < 4; blk++) begin
            for (int i = 0; i < 16; i++) begin wbuf[i] = $urandom; sbuf[i] = 4'hF; end
            do_write(4'(blk), 32'(blk * 64), 8'd15, 16);
        end
        for (int i = 0; i < 8; i++) begin wbuf[i] = $urandom; sbuf[i] = 4'hF; end
        do_write(4'd9, 32'((DEPTH - 8) * 4), 8'd7, 8);

        // Single read of a preloaded word.
        wbuf[0] = 32'hDEADBEEF; sbuf[0] = 4'hF;
        do_write(4'd1, 32'h40, 8'd0, 1);
        do_read(4'd3, 32'h40, 8'd0, 1'b1);

        // Burst write then burst read.
        for (int i = 0; i < 4; i++) begin wbuf[i] = 32'(i + 1); sbuf[i] = 4'hF; end
        do_write(4'd5, 32'h100, 8'd3, 4);
        do_read(4'd6, 32'h100, 8'd3, 1'b1);

        // Byte strobes.
        wbuf[0] = 32'h11223344; sbuf[0] = 4'hF;
        do_write(4'd2, 32'h80, 8'd0, 1);
        wbuf[0] = 32'hAABBCCDD; sbuf[0] = 4'b0101;
        do_write(4'd2, 32'h80, 8'd0, 1);
        do_read(4'd7, 32'h80, 8'd0, 1'b1);

        // Simultaneous AR and AW: the read wins, the write waits for the last R.
        push_read(4'd8, 32'h100, 8'd3);
        wbuf[0] = 32'h5A5A0000; sbuf[0] = 4'hF;
        push_write(4'd10, 32'hC0, 8'd0, 1);
        arid = 4'd8;  araddr = 32'h100; arlen = 8'd3; arvalid = 1'b1;
        awid = 4'd10; awaddr = 32'hC0;  awlen = 8'd0; awvalid = 1'b1;
        @(negedge clk);
        check("both_valid_readies", {30'd0, arready, awready}, 32'd2);
        @(posedge clk);
        #1;
        arvalid = 1'b0;
        n = 0;
        @(negedge clk);
        while (!awready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!awready) timeout_fail("aw_after_read");
        check("aw_after_last_r", rq.size(), 32'd0);
        @(posedge clk);
        #1;
        awvalid = 1'b0;
        send_wbeats(1);
        drain();

        // Read backpressure mid-burst.
        do_read(4'd11, 32'h0, 8'd7, 1'b0);
        n = 0;
        while (rq.size() > 5 && n < 300) begin @(posedge clk); n++; end
        #1;
        rr_stall = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        rr_stall = 1'b0;
        drain();

        // Short write burst -> SLVERR, beats still written.
        for (int i = 0; i < 2; i++) begin wbuf[i] = $urandom; sbuf[i] = 4'hF; end
        do_write(4'd12, 32'h140, 8'd3, 2);
        do_read(4'd12, 32'h140, 8'd1, 1'b1);

        // Top-word write wraps to word 0.
        wbuf[0] = 32'hCAFE0001; wbuf[1] = 32'hCAFE0002; sbuf[0] = 4'hF; sbuf[1] = 4'hF;
        do_write(4'd13, 32'((DEPTH - 1) * 4), 8'd1, 2);
        do_read(4'd13, 32'h0, 8'd0, 1'b1);
        do_read(4'd14, 32'((DEPTH - 1) * 4), 8'd1, 1'b1);

        // Reset while a read beat is stalled in RD_DATA.
        rr_stall = 1'b1;
        do_read(4'd15, 32'h20, 8'd3, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        rq.delete();
        @(negedge clk);
        check("post_rst_rvalid", {31'd0, rvalid}, 32'd0);
        check("post_rst_arready", {31'd0, arready}, 32'd1);
        rr_stall = 1'b0;
        @(posedge clk);
        #1;
        do_read(4'd4, 32'h20, 8'd3, 1'b1);

        // Random mix of reads and writes, including oversize lengths and wrong wlast.
        for (int t = 0; t < 60; t++) begin
            len = 8'($urandom_range(0, 15));
            if ($urandom_range(0, 7) == 0) len[7:4] = 4'($urandom_range(1, 15));
            if ($urandom_range(0, 1) == 0) begin
                do_read(4'($urandom), rand_addr(), len, 1'b1);
            end else begin
                nb = int'(len[3:0]) + 1;
                if ($urandom_range(0, 4) == 0) nb = $urandom_range(1, 16);
                for (int i = 0; i < 16; i++) begin
                    wbuf[i] = $urandom;
                    sbuf[i] = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'hF;
                end
                do_write(4'($urandom), rand_addr(), len, nb);
            end
        end

        drain();
        check("r_scoreboard_empty", rq.size(), 32'd0);
        check("b_scoreboard_empty", bq.size(), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
